// File: rtl/paula_audio_dma_scheduler.sv
// Paula audio DMA slot scheduler: latches channel requests at the horizontal
// strobe and grants one chip-RAM fetch per channel at its fixed colour-clock slot.
module paula_audio_dma_scheduler #(
    parameter logic [8:0] SLOT0   = 9'h00D,
    parameter logic [7:0] AUDBASE = 8'h50
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk7_en,
    input  logic [8:0]  hpos,
    input  logic        strhor,
    input  logic [3:0]  aud_dmaen,
    input  logic [3:0]  dmareq,
    input  logic [3:0]  dmas,
    input  logic [7:0]  reg_address_in,
    input  logic        aen,
    input  logic [15:0] data_in,
    output logic        dma,
    output logic [19:0] address_out,
    output logic [7:0]  reg_address_out
);

    // Addresses are word addresses [20:1], so bit i of these holds address bit i+1.
    logic [19:0] loc_q [4];
    logic [19:0] loc_d [4];
    logic [19:0] ptr_q [4];
    logic [19:0] ptr_d [4];
    logic [3:0]  pending_q, pending_d;
    logic [3:0]  special_q, special_d;
    logic [3:0]  grant;
    logic        unused_data0;

    assign unused_data0 = data_in[0];

    always_comb begin
        grant = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            grant[n] = (hpos == SLOT0 + 9'(2 * n))
                     && pending_q[n] && aud_dmaen[n];
        end
    end

    // Slots never overlap, so at most one grant bit drives the outputs.
    always_comb begin
        dma             = 1'b0;
        address_out     = 20'h00000;
        reg_address_out = 8'hFF;
        for (int n = 0; n < 4; n++) begin
            if (grant[n]) begin
                dma             = 1'b1;
                address_out     = special_q[n] ? loc_q[n] : ptr_q[n];
                reg_address_out = AUDBASE + 8'(8 * n + 5);
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        special_d = special_q;
        for (int n = 0; n < 4; n++) begin
            loc_d[n] = loc_q[n];
            ptr_d[n] = ptr_q[n];
        end
        if (clk7_en) begin
            for (int n = 0; n < 4; n++) begin
                if (aen && reg_address_in == AUDBASE + 8'(8 * n)) begin
                    loc_d[n][19:15] = data_in[4:0];
                end
                if (aen && reg_address_in == AUDBASE + 8'(8 * n + 1)) begin
                    loc_d[n][14:0] = data_in[15:1];
                end
                if (grant[n]) begin
                    ptr_d[n]     = address_out + 20'd1;
                    pending_d[n] = 1'b0;
                    special_d[n] = 1'b0;
                end
            end
            // A new line's requests win over the clear of the slot just served.
            if (strhor) begin
                pending_d = dmareq;
                special_d = dmas & dmareq;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= 4'b0000;
            special_q <= 4'b0000;
            for (int n = 0; n < 4; n++) begin
                loc_q[n] <= 20'h00000;
                ptr_q[n] <= 20'h00000;
            end
        end else begin
            pending_q <= pending_d;
            special_q <= special_d;
            for (int n = 0; n < 4; n++) begin
                loc_q[n] <= loc_d[n];
                ptr_q[n] <= ptr_d[n];
            end
        end
    end

endmodule

// File: tb/tb_paula_audio_dma_scheduler.sv
// Directed bench for the audio DMA slot scheduler.
module tb_paula_audio_dma_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clk7_en;
    logic [8:0]  hpos;
    logic        strhor;
    logic [3:0]  aud_dmaen;
    logic [3:0]  dmareq;
    logic [3:0]  dmas;
    logic [7:0]  reg_address_in;
    logic        aen;
    logic [15:0] data_in;
    logic        dma;
    logic [19:0] address_out;
    logic [7:0]  reg_address_out;

    int tests = 0;
    int fails = 0;

    paula_audio_dma_scheduler dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .clk7_en         (clk7_en),
        .hpos            (hpos),
        .strhor          (strhor),
        .aud_dmaen       (aud_dmaen),
        .dmareq          (dmareq),
        .dmas            (dmas),
        .reg_address_in  (reg_address_in),
        .aen             (aen),
        .data_in         (data_in),
        .dma             (dma),
        .address_out     (address_out),
        .reg_address_out (reg_address_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic ed,
                       input logic [19:0] ea, input logic [7:0] er);
        #1;
        tests++;
        assert (dma === ed) else begin
            fails++;
            $error("FAIL %s dma=%0h expected=%0h", tag, dma, ed);
        end
        tests++;
        assert (address_out === ea) else begin
            fails++;
            $error("FAIL %s address_out=%05h expected=%05h", tag, address_out, ea);
        end
        tests++;
        assert (reg_address_out === er) else begin
            fails++;
            $error("FAIL %s reg_address_out=%02h expected=%02h",
                   tag, reg_address_out, er);
        end
    endtask

    task automatic idle(input string tag);
        chk(tag, 1'b0, 20'h00000, 8'hFF);
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        hpos           = 9'h100;
        aen            = 1'b1;
        reg_address_in = a;
        data_in        = d;
        step();
        aen = 1'b0;
    endtask

    task automatic strobe(input logic [3:0] r, input logic [3:0] s);
        hpos   = 9'h100;
        strhor = 1'b1;
        dmareq = r;
        dmas   = s;
        step();
        strhor = 1'b0;
        dmareq = 4'h0;
        dmas   = 4'h0;
    endtask

    initial begin
        reset_n        = 1'b0;
        clk7_en        = 1'b1;
        hpos           = 9'h100;
        strhor         = 1'b0;
        aud_dmaen      = 4'hF;
        dmareq         = 4'h0;
        dmas           = 4'h0;
        reg_address_in = 8'h00;
        aen            = 1'b0;
        data_in        = 16'h0000;
        #2;
        idle("reset");
        step();
        step();
        reset_n = 1'b1;
        step();
        hpos = 9'h00D;
        idle("no_strhor_after_reset");

        // Special fetch from loc0
        wr(8'h50, 16'h0001);
        wr(8'h51, 16'h2344);
        strobe(4'h1, 4'h1);
        hpos = 9'h00D;
        chk("ch0_special", 1'b1, 20'h091A2, 8'h55);
        step();
        idle("ch0_cleared");
        hpos = 9'h00E;
        idle("between_slots");

        strobe(4'h1, 4'h0);
        hpos = 9'h00D;
        chk("ch0_ptr", 1'b1, 20'h091A3, 8'h55);
        step();

        strobe(4'h0, 4'h0);
        hpos = 9'h00D;
        idle("no_request");
        step();

        // All channels in one line
        strobe(4'hF, 4'h0);
        hpos = 9'h00D;
        chk("all_ch0", 1'b1, 20'h091A4, 8'h55);
        step();
        hpos = 9'h00E;
        idle("all_gap0");
        hpos = 9'h00F;
        chk("all_ch1", 1'b1, 20'h00000, 8'h5D);
        step();
        hpos = 9'h010;
        idle("all_gap1");
        hpos = 9'h011;
        chk("all_ch2", 1'b1, 20'h00000, 8'h65);
        step();
        hpos = 9'h012;
        idle("all_gap2");
        hpos = 9'h013;
        chk("all_ch3", 1'b1, 20'h00000, 8'h6D);
        step();
        hpos = 9'h014;
        idle("all_after");

        // Pointer wrap on ch2
        wr(8'h60, 16'h001F);
        wr(8'h61, 16'hFFFC);
        strobe(4'h4, 4'h4);
        hpos = 9'h011;
        chk("ch2_special", 1'b1, 20'hFFFFE, 8'h65);
        step();
        strobe(4'h4, 4'h0);
        aud_dmaen = 4'b1011;
        hpos = 9'h011;
        idle("ch2_disabled");
        step();
        aud_dmaen = 4'hF;
        chk("ch2_held_top", 1'b1, 20'hFFFFF, 8'h65);
        step();
        strobe(4'h4, 4'h0);
        hpos = 9'h011;
        chk("ch2_wrapped", 1'b1, 20'h00000, 8'h65);
        step();

        // strhor on the grant edge reloads pending
        strobe(4'h1, 4'h0);
        hpos   = 9'h00D;
        strhor = 1'b1;
        dmareq = 4'h1;
        dmas   = 4'h0;
        chk("strhor_grant", 1'b1, 20'h091A5, 8'h55);
        step();
        strhor = 1'b0;
        dmareq = 4'h0;
        chk("strhor_reload", 1'b1, 20'h091A6, 8'h55);
        step();
        idle("reload_served");

        // loc write coinciding with a special grant on ch1
        wr(8'h58, 16'h0002);
        wr(8'h59, 16'h0010);
        strobe(4'h2, 4'h2);
        hpos           = 9'h00F;
        aen            = 1'b1;
        reg_address_in = 8'h59;
        data_in        = 16'h0020;
        chk("ch1_old_loc", 1'b1, 20'h10008, 8'h5D);
        step();
        aen = 1'b0;
        idle("ch1_cleared");
        strobe(4'h2, 4'h2);
        hpos = 9'h00F;
        chk("ch1_new_loc", 1'b1, 20'h10010, 8'h5D);
        step();

        // clk7_en gating
        clk7_en = 1'b0;
        strobe(4'h1, 4'h0);
        clk7_en = 1'b1;
        hpos = 9'h00D;
        idle("strhor_gated");
        strobe(4'h1, 4'h0);
        hpos    = 9'h00D;
        clk7_en = 1'b0;
        step();
        chk("grant_gated", 1'b1, 20'h091A7, 8'h55);
        clk7_en = 1'b1;
        step();
        strobe(4'h1, 4'h0);
        hpos = 9'h00D;
        chk("after_gated", 1'b1, 20'h091A8, 8'h55);

        // Asynchronous reset mid-grant
        reset_n = 1'b0;
        idle("async_reset");
        step();
        reset_n = 1'b1;
        step();
        idle("post_reset_no_grant");
        strobe(4'h1, 4'h1);
        hpos = 9'h00D;
        chk("post_reset_loc", 1'b1, 20'h00000, 8'h55);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
